// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the five-stage core.
// Merges per-stage stall requests into a hold vector and turns a MEM-stage
// exception or ERET into a one-cycle flush with a redirect PC. It also keeps
// stall/flush statistics and a sticky watchdog for stalls that never release.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_BASE   = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000E,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        stall_timeout
);

  // The watchdog counter must hold WDOG_LIMIT itself; keep at least one bit.
  localparam int WDOG_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [5:0]        stall_d;
  logic              flush_d;
  logic [31:0]       new_pc_d;
  logic              exc_accept;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;

  // Decide this cycle's flush/stall/redirect and the next FSM state; while
  // reset is held everything is forced quiet regardless of the requests.
  always_comb begin
    stall_d    = 6'b000000;
    flush_d    = 1'b0;
    new_pc_d   = 32'h0000_0000;
    state_d    = ST_RUN;
    exc_accept = rst && (excepttype_i != 32'h0000_0000) && (state_q != ST_FLUSH);
    if (exc_accept) begin
      flush_d  = 1'b1;
      new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_BASE;
      state_d  = ST_FLUSH;
    end else if (rst) begin
      if (stallreq_mem) begin
        stall_d = 6'b011111;
      end else if (stallreq_ex) begin
        stall_d = 6'b001111;
      end else if (stallreq_id) begin
        stall_d = 6'b000111;
      end else if (stallreq_if) begin
        stall_d = 6'b000011;
      end
      if (stall_d != 6'b000000) begin
        state_d = ST_STALL;
      end
    end
  end

  assign stall      = stall_d;
  assign flush      = flush_d;
  assign new_pc     = new_pc_d;
  assign ctrl_state = state_q;

  // Watchdog next value: counts consecutive stalled edges, saturating at the
  // limit; a flush never coincides with a stall so a released stall clears it.
  always_comb begin
    wdog_d = '0;
    if (stall_d[0] && !flush_d) begin
      wdog_d = (wdog_q == WDOG_MAX) ? WDOG_MAX : wdog_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall-cycle statistic; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0000_0000;
    end else if (stall_d[0]) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Flush statistic; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count <= 16'h0000;
    end else if (flush_d && (flush_count != 16'hFFFF)) begin
      flush_count <= flush_count + 16'd1;
    end
  end

  // Watchdog counter and its sticky flag, which only reset clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (stall_d[0] && (wdog_d == WDOG_MAX)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the five-stage core. Merges stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector consumed by the PC register and every pipeline register (bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB). Converts a MEM-stage exception or ERET into a one-cycle `flush` plus redirect PC. Tracks stall statistics and flags a stall that never releases.

## Interface
- `EXC_BASE`, 32'h0000_0020: redirect target for every exception except ERET.
- `ERET_CODE`, 32'h0000_000E: `excepttype_i` value that denotes ERET.
- `WDOG_LIMIT`, 1023: consecutive stalled cycles that set `stall_timeout`.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stallreq_if` in 1: instruction bus wait.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle EX operation (div, madd/msub).
- `stallreq_mem` in 1: data bus wait.
- `excepttype_i` in 32: MEM-stage exception code. Zero means no exception.
- `cp0_epc_i` in 32: current EPC, used for ERET.
- `stall` out 6: per-stage hold vector.
- `flush` out 1: clears all pipeline registers on the current edge.
- `new_pc` out 32: PC load value, valid while `flush`=1.
- `ctrl_state` out 2: FSM state, 0=RUN, 1=STALL, 2=FLUSH.
- `stall_cycles` out 32: count of cycles with `stall[0]`=1. Wraps.
- `flush_count` out 16: number of flushes. Saturates at 16'hFFFF.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- The exception is accepted when `excepttype_i` != 0 and state != FLUSH. Exception acceptance has top priority.
  - `flush`=1 and `stall`=6'b000000, whatever the stall requests.
  - `new_pc` = `cp0_epc_i` if `excepttype_i` == `ERET_CODE`, else `EXC_BASE`.
- In all other cycles, `flush`=0 and `new_pc`=0.
- Stall vector when there is no accepted exception, first match wins:
  - `stallreq_mem`: 6'b011111
  - `stallreq_ex`: 6'b001111
  - `stallreq_id`: 6'b000111
  - `stallreq_if`: 6'b000011
  - none: 6'b000000
- FSM, with the next state evaluated every edge:
  - Accepted exception: go to FLUSH.
  - Otherwise, `stall` != 0: go to STALL.
  - Otherwise: go to RUN.
- FLUSH lasts exactly one cycle. It masks only `excepttype_i`; stall requests are honoured normally. A nonzero `excepttype_i` that persists into FLUSH is ignored. If it is still present on the following cycle, it is accepted again.
- `stall_cycles` is incremented each edge where `stall[0]`=1. It wraps from 32'hFFFF_FFFF to 0.
- `flush_count` is incremented on each edge with `flush`=1 and holds at 16'hFFFF.
- Watchdog counter (internal, wide enough for `WDOG_LIMIT`):
  - Increments each edge with `stall[0]`=1 and saturates at `WDOG_LIMIT`.
  - Cleared to 0 on any edge with `stall[0]`=0 or `flush`=1.
  - `stall_timeout` is set on the edge where the counter becomes `WDOG_LIMIT`. It is cleared only by reset.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the current inputs and state. There is zero-cycle latency: they are sampled by the PC and pipeline registers on the same edge.
- While `rst`=0, all outputs are forced to 0:
  - `stall`=0, `flush`=0, `new_pc`=0
  - `ctrl_state`=RUN
  - `stall_cycles`=0, `flush_count`=0
  - `stall_timeout`=0, watchdog counter=0
- Reset asserted mid-stall or mid-FLUSH clears all state immediately. It is asynchronous and does not wait for an edge.
- Reset release: the first edge with `rst`=1 evaluates normally.
- An exception together with any stall request yields flush only. `stall_cycles` does not increment on that edge.
- `ctrl_state` and all counters are registered and reflect the previous edge's decision.

## Test plan
- Reset, then all requests held at 0 for 10 cycles:
  - `stall`=0, `flush`=0, `ctrl_state`=RUN, `stall_cycles`=0.
- `stallreq_id` held for 3 cycles, then `stallreq_ex` and `stallreq_id` together for 2 cycles:
  - `stall`=6'b000111 ×3, then 6'b001111 ×2.
  - `stall_cycles`=5, `ctrl_state`=STALL during the stall, RUN after.
- `excepttype_i`=32'h0000_0008 together with `stallreq_mem`=1 for 1 cycle:
  - That cycle: `flush`=1, `new_pc`=32'h20, `stall`=0.
  - Next cycle: `ctrl_state`=FLUSH, `flush_count`=1, `stall`=6'b011111.
- `excepttype_i`=`ERET_CODE` with `cp0_epc_i`=32'h0000_1234:
  - `new_pc`=32'h1234.
  - If held for 3 cycles: flush pattern is 1,0,1 and `flush_count`=2.
- `WDOG_LIMIT` overridden to 4, `stallreq_if` held for 6 cycles:
  - `stall_timeout` rises after the 4th stalled edge.
  - It stays 1 after the request drops, until `rst`=0.
- Assert `rst`=0 asynchronously between edges during a stall, with `stall_cycles`=7:
  - All outputs go to 0 before the next edge.
